sbox_substitute: RTL and testbench
==================================

Name: sbox_substitute

Overview:
- Downstream consumer of the S-box generator. Captures the 256 unique bytes written during generation into forward and inverse tables.
- Once the table is complete, runs a streaming pixel cipher: substitution plus CBC-style chaining, in either encrypt or decrypt mode.
- Sits between the S-box generator (fed by its `data_valid`/V/`done_sbox` signals) and the image output path.

Parameters:
- IV, 8'hA5, initial chaining byte at every frame start.
- CNT_W, 20, width of the per-frame pixel counter (1M pixels).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  one S-box entry present this cycle (generator `data_valid`)
- load_data  in  8  S-box entry, in table-index order (generator V)
- load_done  in  1  level; generator finished (`done_sbox`)
- table_ready  out  1  tables complete and valid; RUN state
- load_err  out  1  sticky; bad load sequence
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at frame_start
- frame_start  in  1  pulse; reset chaining to IV, latch mode, clear pix_count
- in_valid  in  1  input pixel valid
- in_data  in  8  input pixel / cipher byte
- in_last  in  1  final pixel of frame
- in_ready  out  1  block accepts input
- out_valid  out  1  output byte valid
- out_data  out  8  result byte
- out_last  out  1  copy of in_last for this beat
- out_ready  in  1  downstream accepts output
- pix_count  out  CNT_W  beats accepted in current frame

Behaviour:
- Reset values:
  - state = LOAD; load index = 0; entry count = 0.
  - table_ready = 0, load_err = 0, in_ready = 0, out_valid = 0, out_data = 0, out_last = 0, pix_count = 0.
  - chain = IV; latched mode = 0.
  - Table RAM contents are not reset and are never read outside RUN.
- State LOAD:
  - Each cycle with load_valid: write S[idx] = load_data and Sinv[load_data] = idx, then idx++ (8-bit, wraps to 0 after 255) and count++ (9-bit).
  - load_valid when count == 256: write ignored, load_err <= 1.
  - load_done high with count == 256: go to RUN next cycle, table_ready <= 1.
  - load_done high with count < 256: load_err <= 1, stay in LOAD.
  - No duplicate check here; the upstream generator guarantees uniqueness.
- State RUN:
  - Remains in RUN until rst. load_valid and load_done are ignored.
  - in_ready = (state == RUN) && (!out_valid || out_ready). This is combinational and has no dependency on in_valid.
  - Accepted beat: in_valid && in_ready.
  - Output register loads one cycle after acceptance, so latency is 1 and throughput is 1 beat/cycle under out_ready = 1.
  - Encrypt: out_data = S[in_data] ^ c; then c <= out_data.
  - Decrypt: out_data = Sinv[in_data ^ c]; then c <= in_data.
  - out_last <= in_last. pix_count increments on each accepted beat and wraps at 2^CNT_W.
  - Accepted beat with in_last: c <= IV after that beat, so the next frame starts chained from IV even without frame_start.
- frame_start in RUN:
  - c = IV, mode latched, pix_count = 0.
  - If a beat is accepted in the same cycle, that beat uses IV and the new mode input directly, and pix_count becomes 1.
  - frame_start in LOAD is ignored.
- Output handshake:
  - out_valid stays high with out_data/out_last held stable until out_ready.
  - out_valid clears on out_ready unless a new beat is accepted in the same cycle.
- rst mid-frame or mid-load returns to the reset values above. Table contents are stale, and a full 256-entry reload is required.

Test Plan:
- Load S[i] = ~i, 256 beats, then assert load_done → table_ready = 1 on the next cycle, load_err = 0. Check Sinv[8'h00] = 8'hFF by decrypting.
- Encrypt: frame_start with mode = 0, pixels 00, 00, 10 → outputs 5A, A5, 4A (i.e. FF^A5, FF^5A, EF^A5), with 1-cycle latency. Then decrypt 5A, A5, 4A → 00, 00, 10.
- Load only 255 entries, then assert load_done → load_err = 1, table_ready = 0, in_ready = 0. A 257th load_valid after a full load also sets load_err.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 → out_data stable, in_ready = 0, exactly one beat accepted. After release, stream resumes with no loss and no duplication; pix_count is correct.
- In encrypt mode, with frame_start and a beat accepted in the same cycle mid-stream → that beat uses IV; pix_count = 1. Check chain reset after in_last on the next frame.
- rst asserted mid-frame → all outputs return to reset values, state = LOAD, table_ready = 0. Input is refused until a 256-entry reload and load_done.

Source files
------------

// File: rtl/sbox_substitute.sv
`default_nettype none
// ============================================================================
// Module      : sbox_substitute
// Description : Captures the generated S-box into forward and inverse tables,
//               then runs a CBC-chained byte substitution stream in either
//               encrypt or decrypt mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_substitute #(
    parameter logic [7:0] IV    = 8'hA5,
    parameter int         CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    input  logic             load_done,
    output logic             table_ready,
    output logic             load_err,
    input  logic             mode,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pix_count
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_idx;
    logic [8:0]         r_cnt;
    logic [7:0]         r_fwd [256];
    logic [7:0]         r_inv [256];
    logic [7:0]         r_chain;
    logic               r_mode;
    logic               r_table_ready;
    logic               r_load_err;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_pix_count;

    logic               w_full;
    logic               w_write;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_mode_eff;
    logic [7:0]         w_chain_eff;
    logic [7:0]         w_fwd_q;
    logic [7:0]         w_inv_q;
    logic [7:0]         w_result;
    logic [7:0]         w_chain_next;

    // Count saturates at 256, so bit 8 alone marks a complete table.
    assign w_full      = r_cnt[8];
    assign w_write     = (r_state == ST_LOAD) && load_valid && !w_full;
    assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;

    // A beat accepted alongside frame_start must already see IV and the new mode.
    assign w_mode_eff  = frame_start ? mode : r_mode;
    assign w_chain_eff = frame_start ? IV : r_chain;
    assign w_fwd_q     = r_fwd[in_data];
    assign w_inv_q     = r_inv[in_data ^ w_chain_eff];

    always_comb begin
        w_result     = w_fwd_q ^ w_chain_eff;
        w_chain_next = w_result;
        if (w_mode_eff) begin
            w_result     = w_inv_q;
            w_chain_next = in_data;
        end
    end

    // Table storage carries no reset; contents are only read in RUN.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_fwd[r_idx]     <= load_data;
            r_inv[load_data] <= r_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_LOAD;
            r_idx         <= 8'd0;
            r_cnt         <= 9'd0;
            r_chain       <= IV;
            r_mode        <= 1'b0;
            r_table_ready <= 1'b0;
            r_load_err    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 8'd0;
            r_out_last    <= 1'b0;
            r_pix_count   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (load_valid) begin
                        if (w_full) begin
                            r_load_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                            r_cnt <= r_cnt + 9'd1;
                        end
                    end
                    if (load_done) begin
                        if (w_full) begin
                            r_state       <= ST_RUN;
                            r_table_ready <= 1'b1;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        r_mode      <= mode;
                        r_chain     <= IV;
                        r_pix_count <= {CNT_W{1'b0}};
                    end
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                        r_out_last  <= in_last;
                        r_pix_count <= (frame_start ? {CNT_W{1'b0}} : r_pix_count)
                                       + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_chain     <= in_last ? IV : w_chain_next;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign table_ready = r_table_ready;
    assign load_err    = r_load_err;
    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign pix_count   = r_pix_count;

endmodule
`default_nettype wire

// File: tb/tb_sbox_substitute.sv
`default_nettype none
// Directed bench for sbox_substitute: a table-and-chain reference model is
// compared against the DUT every cycle, plus hand-computed byte sequences.
module tb_sbox_substitute;
    localparam logic [7:0] IV    = 8'hA5;
    localparam int         CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [7:0]       load_data = 8'd0;
    logic             load_done = 1'b0;
    logic             table_ready;
    logic             load_err;
    logic             mode = 1'b0;
    logic             frame_start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] pix_count;

    always #5 clk = ~clk;

    sbox_substitute #(.IV(IV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
        .table_ready(table_ready), .load_err(load_err),
        .mode(mode), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .pix_count(pix_count)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tables as arrays, chaining rules as plain arithmetic.
    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];
    logic [7:0] m_idx, m_chain, m_od, m_c, m_r, m_nc;
    int         m_cnt, m_cnt0, m_pix;
    bit         m_run, m_err, m_ov, m_ol, m_mode, m_md, m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_idx = 0; m_cnt = 0; m_err = 0; m_ov = 0; m_od = 0;
            m_ol = 0; m_pix = 0; m_chain = IV; m_mode = 0;
        end else if (!m_run) begin
            m_cnt0 = m_cnt;
            if (load_valid) begin
                if (m_cnt0 == 256) m_err = 1;
                else begin
                    m_fwd[m_idx]     = load_data;
                    m_inv[load_data] = m_idx;
                    m_idx = m_idx + 8'd1;
                    m_cnt++;
                end
            end
            if (load_done) begin
                if (m_cnt0 == 256) m_run = 1;
                else m_err = 1;
            end
        end else begin
            m_acc = in_valid && (!m_ov || out_ready);
            m_c   = frame_start ? IV : m_chain;
            m_md  = frame_start ? mode : m_mode;
            if (frame_start) begin
                m_mode = mode; m_chain = IV; m_pix = 0;
            end
            if (m_acc) begin
                if (!m_md) begin
                    m_r = m_fwd[in_data] ^ m_c; m_nc = m_r;
                end else begin
                    m_r = m_inv[in_data ^ m_c]; m_nc = in_data;
                end
                m_ov = 1; m_od = m_r; m_ol = in_last;
                m_pix = (m_pix + 1) % (1 << CNT_W);
                m_chain = in_last ? IV : m_nc;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("table_ready", 32'(table_ready), 32'(m_run));
            cmp("load_err",    32'(load_err),    32'(m_err));
            cmp("in_ready",    32'(in_ready),    32'(m_run && (!m_ov || out_ready)));
            cmp("out_valid",   32'(out_valid),   32'(m_ov));
            cmp("out_data",    32'(out_data),    32'(m_od));
            cmp("out_last",    32'(out_last),    32'(m_ol));
            cmp("pix_count",   32'(pix_count),   32'(m_pix));
        end
    end

    logic [7:0] capq[$];
    logic [7:0] expq[$];
    always @(negedge clk) if (out_valid && out_ready) capq.push_back(out_data);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_q(input string name);
        cmp({name, "_len"}, 32'(capq.size()), 32'(expq.size()));
        foreach (expq[i])
            if (i < capq.size()) cmp(name, 32'(capq[i]), 32'(expq[i]));
        capq.delete();
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1; load_data = ~8'(i); tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1; tick(); load_done = 1'b0;
    endtask

    task automatic start_frame(input logic m);
        frame_start = 1'b1; mode = m; tick();
        frame_start = 1'b0; mode = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic fs);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l; frame_start = fs; mode = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk); acc = in_ready;
            tick(); frame_start = 1'b0; n++;
        end
        if (!acc) cmp("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        int nacc;
        bit got;
        logic [7:0] held;

        tick(); chk_en = 1'b1;
        tick(); tick();
        cmp("rst_table_ready", 32'(table_ready), 32'(0));
        cmp("rst_out_data", 32'(out_data), 32'(0));
        rst = 1'b0;

        // Short load: 255 entries then done
        load_table(255); pulse_done();
        cmp("short_load_err", 32'(load_err), 32'(1));
        cmp("short_table_ready", 32'(table_ready), 32'(0));
        cmp("short_in_ready", 32'(in_ready), 32'(0));

        // Full load of S[i] = ~i
        rst = 1'b1; tick(); rst = 1'b0;
        load_table(256); pulse_done();
        cmp("full_table_ready", 32'(table_ready), 32'(1));
        cmp("full_load_err", 32'(load_err), 32'(0));

        // Encrypt 00,00,10 -> 5A,A5,4A
        capq.delete();
        start_frame(1'b0);
        send(8'h00, 1'b0, 1'b0);
        cmp("enc_latency_valid", 32'(out_valid), 32'(1));
        cmp("enc_latency_data", 32'(out_data), 32'h5A);
        send(8'h00, 1'b0, 1'b0);
        send(8'h10, 1'b1, 1'b0);
        repeat (3) tick();
        expq = '{8'h5A, 8'hA5, 8'h4A};
        check_q("enc_seq");

        // Decrypt 5A,A5,4A -> 00,00,10 (mode input dropped after frame_start)
        start_frame(1'b1);
        send(8'h5A, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        send(8'h4A, 1'b1, 1'b0);
        repeat (3) tick();
        expq = '{8'h00, 8'h00, 8'h10};
        check_q("dec_seq");

        // Sinv[00] = FF: decrypting A5 from IV
        start_frame(1'b1);
        send(8'hA5, 1'b1, 1'b0);
        repeat (2) tick();
        expq = '{8'hFF};
        check_q("dec_inv00");

        // Backpressure: 5 stalled cycles, exactly one beat taken
        out_ready = 1'b0;
        start_frame(1'b0);
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
        nacc = 0; held = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            got = in_ready;
            if (got) nacc++;
            if (k == 1) held = out_data;
            tick();
            if (got) in_data = 8'h02;
        end
        cmp("bp_accepts", 32'(nacc), 32'(1));
        cmp("bp_pix", 32'(pix_count), 32'(1));
        cmp("bp_in_ready", 32'(in_ready), 32'(0));
        cmp("bp_hold_first", 32'(held), 32'h5B);
        cmp("bp_hold_last", 32'(out_data), 32'h5B);
        out_ready = 1'b1;
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        repeat (3) tick();
        expq = '{8'h5B, 8'hA6, 8'h5A};
        check_q("bp_seq");
        cmp("bp_pix_end", 32'(pix_count), 32'(3));

        // frame_start together with an accepted beat mid-stream
        start_frame(1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        cmp("fs_beat_data", 32'(out_data), 32'h5A);
        cmp("fs_beat_pix", 32'(pix_count), 32'(1));
        send(8'h00, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        expq = '{8'h4B, 8'h96, 8'h5A, 8'hA5, 8'h5A};
        check_q("fs_seq");
        cmp("fs_pix_end", 32'(pix_count), 32'(3));

        // Reset mid-frame, refused input, reload with a 257th entry
        start_frame(1'b0);
        in_valid = 1'b1; in_data = 8'h33; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("mrst_table_ready", 32'(table_ready), 32'(0));
        cmp("mrst_out_valid", 32'(out_valid), 32'(0));
        cmp("mrst_out_data", 32'(out_data), 32'(0));
        cmp("mrst_pix", 32'(pix_count), 32'(0));
        cmp("mrst_in_ready", 32'(in_ready), 32'(0));
        repeat (3) tick();
        in_valid = 1'b0;
        capq.delete();
        load_table(257);
        cmp("extra_load_err", 32'(load_err), 32'(1));
        pulse_done();
        cmp("reload_table_ready", 32'(table_ready), 32'(1));
        start_frame(1'b0);
        send(8'h00, 1'b1, 1'b0);
        repeat (2) tick();
        expq = '{8'h5A};
        check_q("reload_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
